load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide data memory, with
// read-modify-write for sub-word stores. Optional request timeout: LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic        ReqWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic        Err,
  output logic [1:0]  ErrCode,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state_r;
  logic        write_r;
  logic        uns_r;
  logic [1:0]  size_r;
  logic [1:0]  lane_r;
  logic [31:0] wdata_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic [1:0]  err_code_r;
  logic        mem_req_r;
  logic        mem_write_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [31:0] read_data_r;

  logic        misalign_s;
  logic        out_of_range_s;
  logic        timeout_s;

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (lane)
          2'b00:   r[7:0]   = wd[7:0];
          2'b01:   r[15:8]  = wd[7:0];
          2'b10:   r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) r[31:16] = wd[15:0];
        else         r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  // Size 11 is handled as a word everywhere, so Size[1] alone marks a word access.
  assign misalign_s     = ((Size == 2'b01) && Address[0]) || (Size[1] && (Address[1:0] != 2'b00));
  assign out_of_range_s = ({2'b00, Address[31:2]} >= MEM_WORDS_W);

`ifdef LSU_TIMEOUT_EN
  logic [7:0] wait_cnt_r;

  // Unacknowledged request cycles; an ack or an idle bus restarts the count.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wait_cnt_r <= 8'd0;
    end else if (!mem_req_r || MemAck) begin
      wait_cnt_r <= 8'd0;
    end else begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end
  end

  assign timeout_s = mem_req_r && !MemAck && (wait_cnt_r == 8'd254);
`else
  assign timeout_s = 1'b0;
`endif

  // Access sequencer with all outputs registered.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= IDLE;
      write_r     <= 1'b0;
      uns_r       <= 1'b0;
      size_r      <= 2'b00;
      lane_r      <= 2'b00;
      wdata_r     <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= 2'b00;
      mem_req_r   <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      read_data_r <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          err_r      <= 1'b0;
          err_code_r <= 2'b00;
          if (Req) begin
            write_r    <= ReqWrite;
            uns_r      <= Unsigned;
            size_r     <= Size;
            lane_r     <= Address[1:0];
            wdata_r    <= WriteData;
            busy_r     <= 1'b1;
            mem_addr_r <= {2'b00, Address[31:2]};
            if (misalign_s || out_of_range_s) begin
              state_r     <= RESP;
              done_r      <= 1'b1;
              err_r       <= 1'b1;
              err_code_r  <= misalign_s ? 2'b01 : 2'b10;
              read_data_r <= 32'd0;
            end else if (!ReqWrite || !Size[1]) begin
              state_r     <= READ;
              mem_req_r   <= 1'b1;
              mem_write_r <= 1'b0;
            end else begin
              state_r     <= WRITE;
              mem_req_r   <= 1'b1;
              mem_write_r <= 1'b1;
              mem_wdata_r <= WriteData;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (MemAck) begin
            if (write_r) begin
              state_r     <= WRITE;
              mem_write_r <= 1'b1;
              mem_wdata_r <= merge_store(MemRData, size_r, lane_r, wdata_r);
            end else begin
              state_r     <= RESP;
              mem_req_r   <= 1'b0;
              done_r      <= 1'b1;
              read_data_r <= extract_load(MemRData, size_r, lane_r, uns_r);
            end
          end else if (timeout_s) begin
            state_r     <= RESP;
            mem_req_r   <= 1'b0;
            done_r      <= 1'b1;
            err_r       <= 1'b1;
            err_code_r  <= 2'b11;
            read_data_r <= 32'd0;
          end else begin
            state_r <= READ;
          end
        end
        WRITE: begin
          if (MemAck) begin
            state_r     <= RESP;
            mem_req_r   <= 1'b0;
            mem_write_r <= 1'b0;
            done_r      <= 1'b1;
          end else if (timeout_s) begin
            state_r     <= RESP;
            mem_req_r   <= 1'b0;
            mem_write_r <= 1'b0;
            done_r      <= 1'b1;
            err_r       <= 1'b1;
            err_code_r  <= 2'b11;
            read_data_r <= 32'd0;
          end else begin
            state_r <= WRITE;
          end
        end
        RESP: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          err_r      <= 1'b0;
          err_code_r <= 2'b00;
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Err      = err_r;
  assign ErrCode  = err_code_r;
  assign ReadData = read_data_r;
  assign MemReq   = mem_req_r;
  assign MemWrite = mem_write_r;
  assign MemAddr  = mem_addr_r;
  assign MemWData = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random accesses against a
// byte-lane memory model; the memory responder runs inside each transaction task.
module tb_load_store_unit;

  localparam int MEM_WORDS = 1024;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Req = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        Unsigned = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] MemRData = 32'd0;
  logic        MemAck = 1'b0;
  logic        Busy, Done, Err, MemReq, MemWrite;
  logic [1:0]  ErrCode;
  logic [31:0] ReadData, MemAddr, MemWData;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] model_rdata = 32'd0;
  bit          zero_wait = 1'b1;
  int          n_assert = 0;
  int          n_fail = 0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .ReqWrite(ReqWrite), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData), .Busy(Busy),
    .Done(Done), .ReadData(ReadData), .Err(Err), .ErrCode(ErrCode), .MemReq(MemReq),
    .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
    .MemAck(MemAck)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access, called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    int unsigned nbytes, widx, sh, reads, writes, cycles, req_seen, exp_reads, exp_writes;
    logic [31:0] mask, old_w, new_w, ld, ph_addr, ph_wdata;
    logic [1:0]  exp_code;
    logic        in_phase, ph_write, got_done;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    widx   = addr / 4;
    if (addr % nbytes != 0)     exp_code = 2'd1;
    else if (widx >= MEM_WORDS) exp_code = 2'd2;
    else                        exp_code = 2'd0;
    mask  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    sh    = (nbytes == 4) ? 0 : 8 * (addr % 4);
    old_w = 32'd0;
    if (exp_code == 2'd0) old_w = mem[widx];
    ld = (old_w >> sh) & mask;
    if (!uns && ((ld & ((mask >> 1) + 32'd1)) != 32'd0)) ld = ld | ~mask;
    new_w = (old_w & ~(mask << sh)) | ((wd & mask) << sh);
    exp_reads  = (exp_code == 2'd0 && (!w || nbytes < 4)) ? 1 : 0;
    exp_writes = (exp_code == 2'd0 && w) ? 1 : 0;
    if (exp_code != 2'd0) model_rdata = 32'd0;
    else if (!w)          model_rdata = ld;

    Req = 1'b1; ReqWrite = w; Size = sz; Unsigned = uns; Address = addr; WriteData = wd;
    MemAck = 1'b0;
    reads = 0; writes = 0; cycles = 0; req_seen = 0; in_phase = 1'b0; got_done = 1'b0;
    ph_addr = 32'd0; ph_wdata = 32'd0; ph_write = 1'b0;
    while (!got_done && cycles < 100) begin
      @(posedge Clk);
      @(negedge Clk);
      cycles++;
      Req = 1'b0;
      MemAck = 1'b0;
      if (Done) begin
        got_done = 1'b1;
      end else if (MemReq) begin
        req_seen++;
        if (!in_phase) begin
          in_phase = 1'b1; ph_addr = MemAddr; ph_write = MemWrite; ph_wdata = MemWData;
          check("mem_addr", MemAddr, widx);
        end else begin
          check("stable_addr", MemAddr, ph_addr);
          check("stable_write", {31'd0, MemWrite}, {31'd0, ph_write});
          if (ph_write) check("stable_wdata", MemWData, ph_wdata);
        end
        MemRData = (MemAddr < MEM_WORDS) ? mem[MemAddr[9:0]] : $urandom;
        if (zero_wait || $urandom_range(0, 2) == 0) begin
          MemAck = 1'b1;
          in_phase = 1'b0;
          if (MemWrite) begin
            writes++;
            check("rmw_read_first", reads, exp_reads);
            check("store_word", MemWData, new_w);
            if (MemAddr < MEM_WORDS) mem[MemAddr[9:0]] = MemWData;
          end else begin
            reads++;
          end
        end
      end else begin
        MemAck = 1'($urandom_range(0, 1));
        MemRData = $urandom;
        in_phase = 1'b0;
      end
    end
    MemAck = 1'b0;
    check("done_seen", {31'd0, got_done}, 32'd1);
    check("err", {31'd0, Err}, {31'd0, exp_code != 2'd0});
    check("err_code", {30'd0, ErrCode}, {30'd0, exp_code});
    check("read_data", ReadData, model_rdata);
    check("busy_in_resp", {31'd0, Busy}, 32'd1);
    check("mem_reads", reads, exp_reads);
    check("mem_writes", writes, exp_writes);
    check("req_seen", {31'd0, req_seen != 0}, {31'd0, exp_code == 2'd0});
    if (zero_wait) check("latency", cycles, 1 + exp_reads + exp_writes);
    @(posedge Clk);
    @(negedge Clk);
    check("done_one_cycle", {31'd0, Done}, 32'd0);
    check("busy_idle", {31'd0, Busy}, 32'd0);
    check("req_idle", {31'd0, MemReq}, 32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    int          n_done;
    int          stall_cycles;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;

    #2;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    check("rst_err_code", {30'd0, ErrCode}, 32'd0);
    check("rst_mem_req", {31'd0, MemReq}, 32'd0);
    check("rst_mem_write", {31'd0, MemWrite}, 32'd0);
    check("rst_mem_addr", MemAddr, 32'd0);
    check("rst_mem_wdata", MemWData, 32'd0);
    check("rst_read_data", ReadData, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // First request right after release; latency check covers first-edge acceptance.
    zero_wait = 1'b1;
    mem[5] = 32'h8070_60F0;
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0016, 32'd0);
    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'h0000_ABCD);
    check("half_store_word5", mem[5], 32'hABCD_60F0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'd0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'd0);
    run_txn(1'b0, 2'b01, 1'b0, 32'h0000_2001, 32'd0);
    run_txn(1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'hCAFE_F00D);
    run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'd0);
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0016, 32'd0);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'h0000_1000 + $urandom_range(0, 15);
        default: addr = $urandom_range(0, 4 * MEM_WORDS - 1);
      endcase
      zero_wait = ($urandom_range(0, 1) == 0);
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              addr, $urandom);
    end

    // Word store with the memory never acknowledging.
    MemAck = 1'b0;
    Req = 1'b1; ReqWrite = 1'b1; Size = 2'b10; Address = 32'h0000_0020; WriteData = 32'h1234_5678;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
    check("stall_busy", {31'd0, Busy}, 32'd1);
    check("stall_mem_req", {31'd0, MemReq}, 32'd1);
    check("stall_mem_write", {31'd0, MemWrite}, 32'd1);
`ifdef LSU_TIMEOUT_EN
    stall_cycles = 1;
    for (int i = 0; i < 400 && !Done; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (MemReq) stall_cycles++;
    end
    check("timeout_done", {31'd0, Done}, 32'd1);
    check("timeout_req_cycles", stall_cycles, 255);
    check("timeout_err", {31'd0, Err}, 32'd1);
    check("timeout_err_code", {30'd0, ErrCode}, 32'd3);
    check("timeout_read_data", ReadData, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
`else
    n_done = 0;
    stall_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Done) n_done++;
      if (MemReq) stall_cycles++;
    end
    check("no_timeout_done", n_done, 0);
    check("no_timeout_req_cycles", stall_cycles, 300);
    check("no_timeout_busy", {31'd0, Busy}, 32'd1);
    check("no_timeout_err_code", {30'd0, ErrCode}, 32'd0);
`endif

    // Asynchronous reset in the middle of the write phase.
    check("pre_reset_write_phase", {31'd0, MemReq & MemWrite}, 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("arst_mem_req", {31'd0, MemReq}, 32'd0);
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_done", {31'd0, Done}, 32'd0);
    check("arst_mem_write", {31'd0, MemWrite}, 32'd0);
    check("arst_mem_addr", MemAddr, 32'd0);
    check("arst_mem_wdata", MemWData, 32'd0);
    check("arst_read_data", ReadData, 32'd0);
    model_rdata = 32'd0;
    @(negedge Clk);
    check("arst_no_done", {31'd0, Done}, 32'd0);
    Rst_n = 1'b1;
    zero_wait = 1'b1;
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
